data_mem_router: RTL
====================

// Module: data_mem_router
// PURPOSE
//  Parametrised data-memory router between the CPU load/store port and NUM_REGIONS
//  region memories (general data, input/output image RAMs).
//  - Decodes the region, drives per-region byte-lane write enables, and realigns
//    registered read data to the synchronous RAM latency.
//  - Handles byte, half and word access modes with zero or sign extension, and flags
//    misaligned accesses.
// PARAMETERS
//  ADDR_W       32  CPU address width
//  DATA_W       32  data width; byte lanes = DATA_W/8
//  SEL_LSB      16  region select = address_i[SEL_LSB+SEL_W-1:SEL_LSB]
//  NUM_REGIONS  8   number of regions, power of two; SEL_W = $clog2(NUM_REGIONS)
//  RAM_LAT      1   region RAM read latency in cycles (>=1)
//  LED_W        8   LED register width (MMIO_LED_EN only)
//  BTN_W        4   button input width (MMIO_LED_EN only)
// PORTS
//  CLK          in   1                    clock, rising edge
//  RST          in   1                    synchronous reset, active-high
//  req_i        in   1                    access request, single cycle
//  wren_i       in   1                    1 = store, 0 = load
//  address_i    in   ADDR_W               byte address
//  data_i       in   DATA_W               store data, right-aligned
//  byte_mode_i  in   2                    00 byte, 01 half, 10 word, 11 illegal
//  signed_i     in   1                    load sign-extends when 1
//  data_o       out  DATA_W               load data, valid with rvalid_o
//  rvalid_o     out  1                    load data valid pulse
//  err_o        out  1                    misaligned/illegal access pulse
//  reg_addr_o   out  SEL_LSB-2            word address to all regions
//  reg_wdata_o  out  DATA_W               lane-replicated store data
//  reg_be_o     out  DATA_W/8             byte enables
//  reg_we_o     out  NUM_REGIONS          one-hot region write strobe
//  reg_rdata_i  in   NUM_REGIONS*DATA_W   region read data, region k at [k*DATA_W +: DATA_W]
//  leds_o       out  LED_W                LED register (MMIO_LED_EN)
//  btn_i        in   BTN_W                asynchronous buttons (MMIO_LED_EN)
// BEHAVIOUR
//  - Reset: data_o=0, rvalid_o=0, err_o=0, leds_o=0; read pipeline cleared.
//    Store outputs are combinational from the request and are 0 while RST=1.
//  - Store path is combinational in the request cycle:
//    - reg_addr_o = address_i[SEL_LSB-1:2].
//    - reg_we_o[sel] = req_i & wren_i & aligned.
//    - Byte mode: data byte replicated to all lanes; be = 1<<addr[1:0].
//    - Half mode: halfword replicated; be = 2'b11<<addr[1:0].
//    - Word mode: be = all ones.
//  - Alignment:
//    - Half with addr[0]=1, word with addr[1:0]!=0, or mode 11 is an error.
//    - Erroring access: no write strobe; err_o=1 on the cycle after req_i.
//    - Erroring load: still returns rvalid_o with data_o=0.
//  - Load path: a RAM_LAT-deep shift pipeline carries {valid, sel, addr[1:0], mode,
//    signed, err}.
//    - At pipe exit: rvalid_o=1 and data_o = extract(reg_rdata_i[sel]).
//      Total latency: rvalid_o asserts RAM_LAT cycles after req_i.
//    - Extraction shifts right by offset*8 and masks to the mode width, then applies
//      zero extension, or sign extension of bit 7/15 when signed=1.
//  - Back-to-back loads: one per cycle, fully pipelined, in order. A store issued
//    between loads does not disturb pipeline contents.
//  - Simultaneous load exit and new request: both are handled in the same cycle.
//  - RST mid-operation: in-flight loads are discarded and no rvalid_o follows.
//  - Address bits above SEL_LSB+SEL_W-1 are ignored, so region windows wrap.
// CONFIGURATION
//  - MMIO_LED_EN defined: region NUM_REGIONS-1 is MMIO, not RAM, and
//    reg_we_o[NUM_REGIONS-1] is held 0.
//    - Offset 0x0 store: leds_o <= wdata[LED_W-1:0], lane 0 must be enabled.
//      Offset 0x0 load returns leds_o.
//    - Offset 0x4 load returns btn_i through a 2-flop synchronizer, zero-extended.
//    - Other offsets read 0; writes to them are ignored.
//    - MMIO loads use the same RAM_LAT latency.
//  - MMIO_LED_EN undefined: region NUM_REGIONS-1 behaves as a normal RAM region.
//    leds_o is tied 0 and btn_i is unused.
// TESTING
//  1. Word store 0xDEADBEEF @0x0001_0008 -> reg_we_o=8'b0000_0010, be=4'hF,
//     reg_addr_o=2. Load of the same address -> data_o=0xDEADBEEF, RAM_LAT cycles later.
//  2. Byte store 0x5A @0x0000_0003 -> be=4'b1000, wdata=0x5A5A5A5A.
//     Signed byte load with rdata=0x80000000 -> data_o=0xFFFFFF80; unsigned -> 0x00000080.
//  3. Half store @0x0002_0001 -> no reg_we_o, err_o=1 next cycle.
//     Load in mode 11 -> rvalid_o with data_o=0 and err_o=1.
//  4. Four back-to-back loads to regions 0,3,5,0 -> four consecutive rvalid_o, in order,
//     each with its own region's data.
//     RST asserted with two loads in flight -> no further rvalid_o.
//  5. MMIO_LED_EN: store 0xA5 @0x0007_0000 -> leds_o=0xA5 next cycle.
//     btn_i=4'h9 held 3 cycles, then load @0x0007_0004 -> data_o=9.
//     Without the macro, the same store pulses reg_we_o[7].

Source files
------------

// File: rtl/data_mem_router.sv
// CPU load/store router to NUM_REGIONS region RAMs: lane enables, realigned and extended read data.
// Optional build macro MMIO_LED_EN turns the top region into an LED/button MMIO block.
module data_mem_router #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 16,
  parameter int NUM_REGIONS = 8,
  parameter int RAM_LAT     = 1,
  parameter int LED_W       = 8,
  parameter int BTN_W       = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req_i,
  input  logic                          wren_i,
  input  logic [ADDR_W-1:0]             address_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic [1:0]                    byte_mode_i,
  input  logic                          signed_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          rvalid_o,
  output logic                          err_o,
  output logic [SEL_LSB-3:0]            reg_addr_o,
  output logic [DATA_W-1:0]             reg_wdata_o,
  output logic [DATA_W/8-1:0]           reg_be_o,
  output logic [NUM_REGIONS-1:0]        reg_we_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] reg_rdata_i,
  output logic [LED_W-1:0]              leds_o,
  input  logic [BTN_W-1:0]              btn_i
);

  localparam int SEL_W = $clog2(NUM_REGIONS);
  localparam int LANES = DATA_W / 8;
  localparam logic [1:0] M_BYTE = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_WORD = 2'b10;

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] sel;
    logic [1:0]       off;
    logic [1:0]       mode;
    logic             sgn;
    logic             err;
`ifdef MMIO_LED_EN
    logic [1:0]       mmio;
`endif
  } pipe_t;

  logic [SEL_W-1:0] sel;
  logic [1:0]       off;
  logic             mis;
  logic [DATA_W-1:0] wdata;
  logic [LANES-1:0]  be;
  logic [NUM_REGIONS-1:0] we;
  logic              err_d, err_q;
  pipe_t             pipe_d;
  pipe_t             pipe_q [RAM_LAT];
  pipe_t             ex;
  logic [DATA_W-1:0] raw, sh, ext;
  logic              unused_addr;

  assign sel = address_i[SEL_LSB +: SEL_W];
  assign off = address_i[1:0];
  assign unused_addr = ^address_i[ADDR_W-1:SEL_LSB+SEL_W];

  always_comb begin
    mis = (byte_mode_i == 2'b11) |
          ((byte_mode_i == M_HALF) & off[0]) |
          ((byte_mode_i == M_WORD) & (off != 2'b00));
  end

  always_comb begin
    wdata = data_i;
    be    = '0;
    case (byte_mode_i)
      M_BYTE: begin
        wdata = {LANES{data_i[7:0]}};
        be    = LANES'(1) << off;
      end
      M_HALF: begin
        wdata = {(LANES/2){data_i[15:0]}};
        be    = LANES'(3) << off;
      end
      M_WORD:  be = '1;
      default: be = '0;
    endcase
  end

  always_comb begin
    we = '0;
    if (req_i & wren_i & ~mis & ~RST) we[sel] = 1'b1;
`ifdef MMIO_LED_EN
    we[NUM_REGIONS-1] = 1'b0;
`endif
  end

  assign reg_we_o    = we;
  assign reg_be_o    = RST ? '0 : be;
  assign reg_wdata_o = RST ? '0 : wdata;
  assign reg_addr_o  = RST ? '0 : address_i[SEL_LSB-1:2];

  assign err_d = req_i & mis;

  always_comb begin
    pipe_d      = '0;
    pipe_d.vld  = req_i & ~wren_i;
    pipe_d.sel  = sel;
    pipe_d.off  = off;
    pipe_d.mode = byte_mode_i;
    pipe_d.sgn  = signed_i;
    pipe_d.err  = mis;
`ifdef MMIO_LED_EN
    if (address_i[SEL_LSB-1:2] == '0)      pipe_d.mmio = 2'd0;
    else if (address_i[SEL_LSB-1:2] == 1)  pipe_d.mmio = 2'd1;
    else                                   pipe_d.mmio = 2'd2;
`endif
  end

  // Stores never enter the pipe, so loads around them keep their slots.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      err_q <= err_d;
    end
  end

  assign ex = pipe_q[RAM_LAT-1];

`ifdef MMIO_LED_EN
  logic [LED_W-1:0]  leds_d, leds_q;
  logic [BTN_W-1:0]  btn_meta_q, btn_sync_q;
  logic [DATA_W-1:0] mmio_rdata;
  logic              led_wr;

  assign led_wr = req_i & wren_i & ~mis & (sel == SEL_W'(NUM_REGIONS-1)) &
                  (address_i[SEL_LSB-1:2] == '0) & be[0];
  assign leds_d = led_wr ? wdata[LED_W-1:0] : leds_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      leds_q     <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      leds_q     <= leds_d;
      btn_meta_q <= btn_i;
      btn_sync_q <= btn_meta_q;
    end
  end

  always_comb begin
    case (ex.mmio)
      2'd0:    mmio_rdata = DATA_W'(leds_q);
      2'd1:    mmio_rdata = DATA_W'(btn_sync_q);
      default: mmio_rdata = '0;
    endcase
  end

  assign leds_o = leds_q;
`else
  logic unused_btn;
  assign unused_btn = ^btn_i;
  assign leds_o     = '0;
`endif

  always_comb begin
    raw = reg_rdata_i[ex.sel*DATA_W +: DATA_W];
`ifdef MMIO_LED_EN
    if (ex.sel == SEL_W'(NUM_REGIONS-1)) raw = mmio_rdata;
`endif
    sh = raw >> {ex.off, 3'b000};
    case (ex.mode)
      M_BYTE:  ext = {{(DATA_W-8){ex.sgn & sh[7]}}, sh[7:0]};
      M_HALF:  ext = {{(DATA_W-16){ex.sgn & sh[15]}}, sh[15:0]};
      M_WORD:  ext = sh;
      default: ext = '0;
    endcase
    if (ex.err) ext = '0;
  end

  // Gating by RST keeps an in-flight load from surfacing in the first reset cycle.
  assign rvalid_o = ex.vld & ~RST;
  assign data_o   = rvalid_o ? ext : '0;
  assign err_o    = err_q & ~RST;

endmodule
